// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter plus return-address stack for the PBL core.
// Steps, jumps, calls and returns once per enabled cycle; traps overflow,
// underflow and illegal cal+ret combinations in a FAULT state until cleared.
// Optional feature macro: PC_SEQ_STACK_WRAP_EN -- when defined, the stack is
// a circular buffer and a call on a full stack overwrites the oldest entry.
module pc_sequencer #(
    parameter int PC_WIDTH    = 5,
    parameter int STACK_DEPTH = 8,
    parameter int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   jmp,
    input  logic                   cal,
    input  logic                   ret,
    input  logic [PC_WIDTH-1:0]    jmp_addr,
    input  logic                   clear_fault,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [DEPTH_WIDTH-1:0] depth,
    output logic [PC_WIDTH-1:0]    stack_top,
    output logic                   stack_full,
    output logic                   stack_empty,
    output logic                   fault,
    output logic [1:0]             fault_code
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = DEPTH_WIDTH'(STACK_DEPTH);

    localparam logic [1:0] FC_NONE      = 2'd0;
    localparam logic [1:0] FC_OVERFLOW  = 2'd1;
    localparam logic [1:0] FC_UNDERFLOW = 2'd2;
    localparam logic [1:0] FC_ILLEGAL   = 2'd3;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
    logic [1:0]             code_q, code_d;
    logic                   push, pop;
    logic                   full, empty;
    logic [PC_WIDTH-1:0]    ret_addr;
    logic [IDX_W-1:0]       wr_idx, rd_idx;

    // Return-address storage; data only, so it is never reset.
    logic [PC_WIDTH-1:0]    stack_mem [STACK_DEPTH];

    assign full     = (depth_q == DEPTH_MAX);
    assign empty    = (depth_q == '0);
    assign ret_addr = pc_q + 1'b1;

`ifdef PC_SEQ_STACK_WRAP_EN
    // Circular buffer: top_ptr is the next write slot, bot_ptr the oldest entry.
    logic [IDX_W-1:0] top_ptr, bot_ptr;
    logic             clr;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(STACK_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] ptr_dec(input logic [IDX_W-1:0] p);
        return (p == '0) ? IDX_W'(STACK_DEPTH - 1) : p - 1'b1;
    endfunction

    assign clr    = (state_q == FAULT) && clear_fault;
    // When full, top and bottom coincide; writing at bot_ptr evicts the oldest.
    assign wr_idx = full ? bot_ptr : top_ptr;
    assign rd_idx = ptr_dec(top_ptr);

    // Pointer maintenance; a fault clear empties the buffer like a reset.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            top_ptr <= '0;
            bot_ptr <= '0;
        end else if (push) begin
            top_ptr <= ptr_inc(top_ptr);
            if (full) begin
                bot_ptr <= ptr_inc(bot_ptr);
            end
        end else if (pop) begin
            top_ptr <= ptr_dec(top_ptr);
        end
    end
`else
    // Linear stack: entry i lives at index i, so the top is depth-1.
    assign wr_idx = IDX_W'(depth_q);
    assign rd_idx = IDX_W'(depth_q - 1'b1);
`endif

    // Next-state, next-PC and stack-operation decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        code_d  = code_q;
        push    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            RUN: begin
                if (en) begin
                    if (cal && ret) begin
                        state_d = FAULT;
                        code_d  = FC_ILLEGAL;
                    end else if (cal) begin
`ifdef PC_SEQ_STACK_WRAP_EN
                        push = 1'b1;
                        pc_d = jmp_addr;
                        if (!full) begin
                            depth_d = depth_q + 1'b1;
                        end
`else
                        if (full) begin
                            state_d = FAULT;
                            code_d  = FC_OVERFLOW;
                        end else begin
                            push    = 1'b1;
                            depth_d = depth_q + 1'b1;
                            pc_d    = jmp_addr;
                        end
`endif
                    end else if (ret) begin
                        if (empty) begin
                            state_d = FAULT;
                            code_d  = FC_UNDERFLOW;
                        end else begin
                            pop     = 1'b1;
                            depth_d = depth_q - 1'b1;
                            pc_d    = stack_mem[rd_idx];
                        end
                    end else if (jmp) begin
                        pc_d = jmp_addr;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    state_d = RUN;
                    pc_d    = '0;
                    depth_d = '0;
                    code_d  = FC_NONE;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= '0;
            depth_q <= '0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            code_q  <= code_d;
        end
    end

    // Return-address write on every accepted call.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack_mem[wr_idx] <= ret_addr;
        end
    end

    assign pc          = pc_q;
    assign depth       = depth_q;
    assign stack_top   = empty ? '0 : stack_mem[rd_idx];
    assign stack_full  = full;
    assign stack_empty = empty;
    assign fault       = (state_q == FAULT);
    assign fault_code  = code_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       jmp = 1'b0;
    logic       cal = 1'b0;
    logic       ret = 1'b0;
    logic [4:0] jmp_addr = '0;
    logic       clear_fault = 1'b0;
    logic [4:0] pc;
    logic [3:0] depth;
    logic [4:0] stack_top;
    logic       stack_full;
    logic       stack_empty;
    logic       fault;
    logic [1:0] fault_code;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .jmp(jmp), .cal(cal), .ret(ret),
        .jmp_addr(jmp_addr), .clear_fault(clear_fault), .pc(pc), .depth(depth),
        .stack_top(stack_top), .stack_full(stack_full), .stack_empty(stack_empty),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic e, input logic j, input logic c,
                        input logic rt, input logic [4:0] a, input logic cf);
        rst = r; en = e; jmp = j; cal = c; ret = rt; jmp_addr = a; clear_fault = cf;
        @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b0; jmp = 1'b0; cal = 1'b0; ret = 1'b0; clear_fault = 1'b0;
    endtask

    initial begin
        // Reset values
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_depth", 32'(depth), 0);
        chk("rst_top", 32'(stack_top), 0);
        chk("rst_empty", 32'(stack_empty), 1);
        chk("rst_full", 32'(stack_full), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_code", 32'(fault_code), 0);

        // Free-running count with wrap: 33 steps end at pc=1
        for (int k = 1; k <= 33; k++) begin
            step(0, 1, 0, 0, 0, 0, 0);
            chk("run_pc", 32'(pc), k % 32);
            chk("run_fault", 32'(fault), 0);
        end
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("pre_call_pc", 32'(pc), 3);

        // en=0 holds even with a jump strobe
        step(0, 0, 1, 0, 0, 5'd9, 0);
        chk("en0_hold_pc", 32'(pc), 3);

        // Call / idle / return
        step(0, 1, 1, 1, 0, 5'd20, 0);
        chk("call_pc", 32'(pc), 20);
        chk("call_depth", 32'(depth), 1);
        chk("call_top", 32'(stack_top), 4);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("idle_pc", 32'(pc), 21);
        chk("idle_top", 32'(stack_top), 4);
        step(0, 1, 0, 0, 1, 0, 0);
        chk("ret_pc", 32'(pc), 4);
        chk("ret_depth", 32'(depth), 0);
        chk("ret_top_empty", 32'(stack_top), 0);

        // clear_fault in RUN has no effect; plain jump
        step(0, 1, 0, 0, 0, 0, 1);
        chk("clr_in_run_pc", 32'(pc), 5);
        step(0, 1, 1, 0, 0, 5'd30, 0);
        chk("jmp_pc", 32'(pc), 30);
        chk("jmp_depth", 32'(depth), 0);

        // Nine consecutive calls
        step(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, 1, 1, 0, 5'd10, 0);
            chk("fill_depth", 32'(depth), k);
            chk("fill_pc", 32'(pc), 10);
            chk("fill_top", 32'(stack_top), (k == 1) ? 1 : 11);
        end
        chk("fill_full", 32'(stack_full), 1);
        step(0, 1, 1, 1, 0, 5'd10, 0);
`ifdef PC_SEQ_STACK_WRAP_EN
        chk("wrap_fault", 32'(fault), 0);
        chk("wrap_depth", 32'(depth), 8);
        for (int k = 7; k >= 0; k--) begin
            step(0, 1, 0, 0, 1, 0, 0);
            chk("wrap_unwind_pc", 32'(pc), 11);
            chk("wrap_unwind_depth", 32'(depth), k);
        end
        step(0, 1, 0, 0, 1, 0, 0);
        chk("wrap_uf_fault", 32'(fault), 1);
        chk("wrap_uf_code", 32'(fault_code), 2);
`else
        chk("ovf_fault", 32'(fault), 1);
        chk("ovf_code", 32'(fault_code), 1);
        chk("ovf_pc", 32'(pc), 10);
        chk("ovf_depth", 32'(depth), 8);
`endif
        step(0, 0, 0, 0, 0, 0, 1);
        chk("clr_fault", 32'(fault), 0);
        chk("clr_pc", 32'(pc), 0);
        chk("clr_depth", 32'(depth), 0);
        chk("clr_top", 32'(stack_top), 0);
        chk("clr_code", 32'(fault_code), 0);

        // Underflow straight after reset, frozen while faulted
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        chk("uf_code", 32'(fault_code), 2);
        chk("uf_pc", 32'(pc), 0);
        step(0, 1, 1, 0, 0, 5'd17, 0);
        chk("frozen_pc", 32'(pc), 0);
        chk("frozen_fault", 32'(fault), 1);
        step(0, 1, 0, 0, 0, 0, 1);
        chk("uf_clr_fault", 32'(fault), 0);
        chk("uf_clr_pc", 32'(pc), 0);

        // Illegal cal+ret at pc=7, depth=2
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 5'd5, 0);
        step(0, 1, 1, 1, 0, 5'd6, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("pre_ill_pc", 32'(pc), 7);
        step(0, 1, 1, 1, 1, 5'd12, 0);
        chk("ill_code", 32'(fault_code), 3);
        chk("ill_pc", 32'(pc), 7);
        chk("ill_depth", 32'(depth), 2);
        chk("ill_top", 32'(stack_top), 6);
        step(0, 0, 0, 0, 0, 0, 1);

        // Back-to-back call then return lands on the pushed address
        step(0, 1, 1, 1, 0, 5'd20, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        chk("b2b_pc", 32'(pc), 1);
        chk("b2b_depth", 32'(depth), 0);

        // Reset dominates a call at depth 3
        step(0, 1, 1, 1, 0, 5'd2, 0);
        step(0, 1, 1, 1, 0, 5'd3, 0);
        step(0, 1, 1, 1, 0, 5'd4, 0);
        chk("pre_rst_depth", 32'(depth), 3);
        step(1, 1, 1, 1, 0, 5'd8, 0);
        chk("rst_call_pc", 32'(pc), 0);
        chk("rst_call_depth", 32'(depth), 0);
        chk("rst_call_fault", 32'(fault), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
